// File: rtl/obstacle_pkg.sv
// Shared FSM encoding, obstacle type codes and the scroll-speed helper for the obstacle scheduler.
// Speed is base + score/16; define OBST_SPEED_CAP_EN to clamp it at the caller's ceiling.
package obstacle_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MOVE  = 2'd1;
   localparam logic [1:0] ST_SPAWN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      OBST_SMALL = 2'd0,
      OBST_BIG   = 2'd1,
      OBST_PTERO = 2'd2,
      OBST_RSVD  = 2'd3
   } obst_type_e;

   localparam int XW_DEF = 13;

`ifdef OBST_SPEED_CAP_EN
   localparam bit SPEED_CAP_EN = 1'b1;
`else
   localparam bit SPEED_CAP_EN = 1'b0;
`endif

   function automatic logic [6:0] calc_speed(input logic [9:0] score_v,
                                             input logic [6:0] base,
                                             input logic [6:0] cap);
      logic [6:0] s;
      s = base + {1'b0, score_v[9:4]};
      if (SPEED_CAP_EN && (s > cap))
         s = cap;
      return s;
   endfunction

endpackage

// File: rtl/obstacle_scheduler.sv
// Obstacle slot pool: per-frame move/retire of each slot, round-robin spawn, score and speed.
// Latency: done pulses NUM_SLOTS+2 cycles after an accepted frame_tick; ticks arriving while busy
// are dropped and flagged in the sticky overrun bit. Speed cap selected by OBST_SPEED_CAP_EN.
module obstacle_scheduler
   import obstacle_pkg::*;
#(
   parameter int NUM_SLOTS  = 3,
   parameter int XW         = XW_DEF,
   parameter int SPAWN_X    = 640,
   parameter int FIRST_X    = 630,
   parameter int RETIRE_X   = -40,
   parameter int MIN_GAP    = 250,
   parameter int BASE_SPEED = 4,
   parameter int MAX_SPEED  = 16
) (
   input  logic                    pclk,
   input  logic                    rst,
   input  logic                    frame_tick,
   input  logic                    run,
   input  logic                    clear,
   input  logic [9:0]              rand_val,
   output logic [NUM_SLOTS*XW-1:0] obj_x,
   output logic [NUM_SLOTS*2-1:0]  obj_type,
   output logic [NUM_SLOTS-1:0]    obj_active,
   output logic [9:0]              score,
   output logic [6:0]              speed,
   output logic                    busy,
   output logic                    done,
   output logic                    overrun
);

   localparam int                     IW        = (NUM_SLOTS > 2) ? 2 : 1;
   localparam logic [IW-1:0]          LAST_IDX  = IW'(NUM_SLOTS - 1);
   localparam logic signed [XW-1:0]   FIRST_XV  = XW'(FIRST_X);
   localparam logic signed [XW-1:0]   SPAWN_XV  = XW'(SPAWN_X);
   localparam int                     GAP_BASE  = SPAWN_X - MIN_GAP;
   localparam logic [6:0]             BASE_V    = 7'(BASE_SPEED);
   localparam logic [6:0]             MAX_V     = 7'(MAX_SPEED);

   logic [1:0]            state;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         newest;
   logic [IW-1:0]         nxt;
   logic [8:0]            gap_off;
   logic [6:0]            speed_q;
   logic signed [XW-1:0]  x_q [NUM_SLOTS];
   obst_type_e            type_q [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]  active_q;
   logic signed [XW-1:0]  nx;
   logic                  spawn_ok;

   assign nx       = x_q[idx] - $signed({{(XW-7){1'b0}}, speed_q});
   assign nxt      = (newest == LAST_IDX) ? '0 : newest + IW'(1);
   // Spacing is measured from the newest slot even if it has already retired.
   assign spawn_ok = int'(x_q[newest]) < (GAP_BASE - int'(gap_off));

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         newest  <= '0;
         gap_off <= '0;
         speed_q <= BASE_V;
         score   <= '0;
         speed   <= BASE_V;
         overrun <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            x_q[i]      <= (i == 0) ? FIRST_XV : '0;
            type_q[i]   <= OBST_SMALL;
            active_q[i] <= (i == 0);
         end
      end else if (clear) begin
         state   <= ST_IDLE;
         idx     <= '0;
         newest  <= '0;
         gap_off <= '0;
         speed_q <= BASE_V;
         score   <= '0;
         speed   <= BASE_V;
         overrun <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            x_q[i]      <= (i == 0) ? FIRST_XV : '0;
            type_q[i]   <= OBST_SMALL;
            active_q[i] <= (i == 0);
         end
      end else begin
         if (frame_tick && (state != ST_IDLE))
            overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (frame_tick && run) begin
                  state   <= ST_MOVE;
                  idx     <= '0;
                  speed_q <= speed;
               end
            end
            ST_MOVE: begin
               if (active_q[idx]) begin
                  if (nx < RETIRE_X) begin
                     active_q[idx] <= 1'b0;
                     if (score != 10'h3FF)
                        score <= score + 10'd1;
                  end else begin
                     x_q[idx] <= nx;
                  end
               end
               if (idx == LAST_IDX)
                  state <= ST_SPAWN;
               else
                  idx <= idx + IW'(1);
            end
            ST_SPAWN: begin
               if (spawn_ok && !active_q[nxt]) begin
                  x_q[nxt]      <= SPAWN_XV;
                  type_q[nxt]   <= obst_type_e'(rand_val[9:8]);
                  active_q[nxt] <= 1'b1;
                  newest        <= nxt;
                  gap_off       <= rand_val[8:0];
               end
               state <= ST_DONE;
            end
            default: begin
               speed <= calc_speed(score, BASE_V, MAX_V);
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      obj_x    = '0;
      obj_type = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         obj_x[i*XW +: XW]  = x_q[i];
         obj_type[i*2 +: 2] = type_q[i];
      end
   end

   assign obj_active = active_q;
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: default-parameter DUT plus a short-gap DUT to reach slot exhaustion.
module tb_obstacle_scheduler;

   logic        pclk = 1'b0;
   logic        rst, frame_tick, run, clear;
   logic [9:0]  rand_val;

   logic [38:0] obj_x, g_obj_x;
   logic [5:0]  obj_type, g_obj_type;
   logic [2:0]  obj_active, g_obj_active;
   logic [9:0]  score, g_score;
   logic [6:0]  speed, g_speed;
   logic        busy, g_busy, done, g_done, overrun, g_overrun;

   int checks = 0;
   int errors = 0;

   int cap_g_score, cap_g_speed;

   always #5 pclk = ~pclk;

   obstacle_scheduler dut (
      .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .run(run), .clear(clear),
      .rand_val(rand_val), .obj_x(obj_x), .obj_type(obj_type), .obj_active(obj_active),
      .score(score), .speed(speed), .busy(busy), .done(done), .overrun(overrun)
   );

   obstacle_scheduler #(.MIN_GAP(100)) dut_gap (
      .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .run(run), .clear(clear),
      .rand_val(rand_val), .obj_x(g_obj_x), .obj_type(g_obj_type), .obj_active(g_obj_active),
      .score(g_score), .speed(g_speed), .busy(g_busy), .done(g_done), .overrun(g_overrun)
   );

   typedef struct {
      bit         clr;
      bit         use_gap;
      int         n;
      logic [9:0] rv;
      int         x0;
      int         x1;
      int         x2;
      logic [2:0] act;
      logic [5:0] typ;
      int         sc;
   } vec_t;

   typedef struct {
      logic [9:0] sc;
      int         exp_speed;
   } spd_t;

   vec_t tbl[13];
   spd_t stbl[5];

   function automatic int gx(input logic [38:0] v, input int i);
      logic signed [12:0] t;
      t = v[i*13 +: 13];
      return int'(t);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Caller is at a negedge; returns one cycle after done, back in IDLE.
   task automatic tick_frame();
      bit seen;
      seen = 1'b0;
      frame_tick = 1'b1;
      @(negedge pclk);
      frame_tick = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (done) begin
            seen = 1'b1;
            cap_g_score = int'(g_score);
            cap_g_speed = int'(g_speed);
            break;
         end
         @(negedge pclk);
      end
      if (!seen)
         chk("frame_done_timeout", 0, 1);
      @(negedge pclk);
   endtask

   task automatic run_frames(input int n);
      for (int k = 0; k < n; k++)
         tick_frame();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge pclk);
      clear = 1'b0;
   endtask

   initial begin
      logic [38:0] ax;
      logic [5:0]  at;
      logic [2:0]  aa;
      int          asc;
      bit          found;

      rst = 1'b1; run = 1'b0; clear = 1'b0; frame_tick = 1'b0; rand_val = '0;

      tbl[0]  = '{1'b1, 1'b0, 60,  10'h300, 390, 0,   0,   3'b001, 6'b000000, 0};
      tbl[1]  = '{1'b0, 1'b0, 1,   10'h300, 386, 640, 0,   3'b011, 6'b001100, 0};
      tbl[2]  = '{1'b0, 1'b0, 106, 10'h300, -38, 216, 0,   3'b011, 6'b001100, 0};
      tbl[3]  = '{1'b0, 1'b0, 1,   10'h300, -38, 212, 0,   3'b010, 6'b001100, 1};
      tbl[4]  = '{1'b0, 1'b0, 19,  10'h300, -38, 136, 0,   3'b010, 6'b001100, 1};
      tbl[5]  = '{1'b0, 1'b0, 1,   10'h300, -38, 132, 640, 3'b110, 6'b111100, 1};
      tbl[6]  = '{1'b1, 1'b1, 22,  10'h000, 542, 0,   0,   3'b001, 6'b000000, 0};
      tbl[7]  = '{1'b0, 1'b1, 1,   10'h000, 538, 640, 0,   3'b011, 6'b000000, 0};
      tbl[8]  = '{1'b0, 1'b1, 25,  10'h000, 438, 540, 0,   3'b011, 6'b000000, 0};
      tbl[9]  = '{1'b0, 1'b1, 1,   10'h000, 434, 536, 640, 3'b111, 6'b000000, 0};
      tbl[10] = '{1'b0, 1'b1, 26,  10'h000, 330, 432, 536, 3'b111, 6'b000000, 0};
      tbl[11] = '{1'b0, 1'b1, 92,  10'h000, -38, 64,  168, 3'b111, 6'b000000, 0};
      tbl[12] = '{1'b0, 1'b1, 1,   10'h000, 640, 60,  164, 3'b111, 6'b000000, 1};

      stbl[0] = '{10'd0,  4};
      stbl[1] = '{10'd15, 4};
      stbl[2] = '{10'd16, 5};
`ifdef OBST_SPEED_CAP_EN
      stbl[3] = '{10'd255,  16};
      stbl[4] = '{10'd1023, 16};
`else
      stbl[3] = '{10'd255,  19};
      stbl[4] = '{10'd1023, 67};
`endif

      repeat (3) @(negedge pclk);
      rst = 1'b0;
      @(negedge pclk);
      chk("rst_active", int'(obj_active), 1);
      chk("rst_x0", gx(obj_x, 0), 630);
      chk("rst_x1", gx(obj_x, 1), 0);
      chk("rst_type", int'(obj_type), 0);
      chk("rst_score", int'(score), 0);
      chk("rst_speed", int'(speed), 4);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);

      // First frame: busy for 5 cycles, done in the 5th, extra tick in cycle 3 is dropped.
      run = 1'b1;
      frame_tick = 1'b1;
      @(negedge pclk);
      frame_tick = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         chk($sformatf("busy_c%0d", c), int'(busy), int'(c <= 5));
         chk($sformatf("done_c%0d", c), int'(done), int'(c == 5));
         frame_tick = (c == 3);
         @(negedge pclk);
      end
      chk("frame1_x0", gx(obj_x, 0), 626);
      chk("overrun_set", int'(overrun), 1);
      repeat (4) @(negedge pclk);
      chk("dropped_tick_x0", gx(obj_x, 0), 626);

      // run low in IDLE freezes everything.
      run = 1'b0;
      frame_tick = 1'b1;
      @(negedge pclk);
      frame_tick = 1'b0;
      repeat (8) @(negedge pclk);
      chk("run_low_x0", gx(obj_x, 0), 626);
      chk("run_low_busy", int'(busy), 0);

      // clear while slot 1 is being processed aborts the update.
      run = 1'b1;
      frame_tick = 1'b1;
      @(negedge pclk);
      frame_tick = 1'b0;
      @(negedge pclk);
      pulse_clear();
      chk("clr_busy", int'(busy), 0);
      chk("clr_x0", gx(obj_x, 0), 630);
      chk("clr_active", int'(obj_active), 1);
      chk("clr_overrun", int'(overrun), 0);
      chk("clr_score", int'(score), 0);
      chk("clr_speed", int'(speed), 4);

      for (int r = 0; r < 13; r++) begin
         if (tbl[r].clr)
            pulse_clear();
         rand_val = tbl[r].rv;
         run_frames(tbl[r].n);
         if (tbl[r].use_gap) begin
            ax = g_obj_x; at = g_obj_type; aa = g_obj_active; asc = int'(g_score);
         end else begin
            ax = obj_x;   at = obj_type;   aa = obj_active;   asc = int'(score);
         end
         chk($sformatf("row%0d_x0", r), gx(ax, 0), tbl[r].x0);
         chk($sformatf("row%0d_x1", r), gx(ax, 1), tbl[r].x1);
         chk($sformatf("row%0d_x2", r), gx(ax, 2), tbl[r].x2);
         chk($sformatf("row%0d_active", r), int'(aa), int'(tbl[r].act));
         chk($sformatf("row%0d_type", r), int'(at), int'(tbl[r].typ));
         chk($sformatf("row%0d_score", r), asc, tbl[r].sc);
      end

      // Score 15 -> 16: speed is still 4 during that DONE, 5 once back in IDLE.
      found = 1'b0;
      for (int f = 0; f < 1500 && !found; f++) begin
         tick_frame();
         if (cap_g_score == 16) begin
            found = 1'b1;
            chk("speed_in_done", cap_g_speed, 4);
            chk("speed_after_done", int'(g_speed), 5);
         end
      end
      chk("score_reached_16", int'(found), 1);

      for (int s = 0; s < 5; s++)
         chk($sformatf("calc_speed_%0d", stbl[s].sc),
             int'(obstacle_pkg::calc_speed(stbl[s].sc, 7'd4, 7'd16)), stbl[s].exp_speed);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Owns the pool of obstacle slots for the runner game: moves every active slot once per frame, retires slots that leave the screen, spawns new obstacles round-robin with a randomized gap, and keeps score and scroll speed.
- Sits between the game FSM / LFSR and the collision and sprite-address logic, which read its slot outputs.
- Slots are updated sequentially, one slot per cycle, after each frame tick.

Parameters:
NUM_SLOTS, 3, number of obstacle slots (2..4)
XW, 13, signed X coordinate width
SPAWN_X, 640, X assigned to a newly spawned obstacle
FIRST_X, 630, X of slot 0 after reset/clear
RETIRE_X, -40, slot retires when its new X < RETIRE_X
MIN_GAP, 250, minimum spawn distance in pixels
BASE_SPEED, 4, pixels/frame at score 0
MAX_SPEED, 16, speed ceiling (used only with OBST_SPEED_CAP_EN)

Ports:
pclk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
run  in  1  game is in RUN state; frame_tick is ignored when low
clear  in  1  synchronous restart pulse
rand_val  in  10  LFSR output, sampled when used
obj_x  out  NUM_SLOTS*XW  signed X per slot, slot i at [i*XW +: XW]
obj_type  out  NUM_SLOTS*2  obstacle type per slot
obj_active  out  NUM_SLOTS  slot valid
score  out  10  obstacles passed, saturating at 1023
speed  out  7  current scroll speed, pixels/frame
busy  out  1  update in progress
done  out  1  one-cycle pulse when a frame update completes
overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
Reset and clear state:
- slot 0 active at FIRST_X, type 0; other slots inactive, X=0, type 0.
- newest=0, gap_off=0, score=0, speed=BASE_SPEED, state IDLE, busy/done/overrun=0.
- clear is synchronous and has highest priority: it aborts any update in progress and clears overrun.

FSM (IDLE -> MOVE -> SPAWN -> DONE -> IDLE):
- IDLE: frame_tick && run -> MOVE, idx=0, busy=1, speed_q latched = speed.
- MOVE: one slot per cycle for idx=0..NUM_SLOTS-1.
  - Active slot: nx = x - speed_q (signed XW arithmetic).
  - If nx < RETIRE_X: active<=0 and score+1 (saturating).
  - Otherwise x<=nx.
  - Inactive slots are untouched.
  - After the last idx -> SPAWN.
- SPAWN: n = (newest+1) mod NUM_SLOTS.
  - Condition: obj_x[newest] < SPAWN_X - MIN_GAP - gap_off (signed compare), using the post-move X; this holds even if newest has already retired.
  - If the condition holds and slot n is inactive: x[n]<=SPAWN_X, type[n]<=rand_val[9:8], active[n]<=1, newest<=n, gap_off<=rand_val[8:0].
  - If slot n is active: no spawn; retry on the next frame.
- DONE: done=1 for one cycle, busy=0 -> IDLE. speed recomputed from the updated score here.
- Latency: done is asserted exactly NUM_SLOTS+2 cycles after the accepted frame_tick.

Speed:
- speed = BASE_SPEED + score[9:4], computed unsigned in 7 bits.
- Speed is constant for the whole update because it is latched as speed_q.

Boundaries:
- frame_tick while busy: dropped, overrun<=1.
- run deasserted mid-update: the update completes.
- run low in IDLE: all state frozen.
- Score at 1023 stays 1023.
- Only one spawn per frame.

Optional Feature:
- Macro: OBST_SPEED_CAP_EN.
- Defined: speed = min(BASE_SPEED + score[9:4], MAX_SPEED).
- Undefined: speed is uncapped (maximum 67 at default parameters) and MAX_SPEED is unused.

Decomposition:
- Package obstacle_pkg holds:
  - FSM state encoding (2 bits).
  - Type codes: OBST_SMALL=0, OBST_BIG=1, OBST_PTERO=2, OBST_RSVD=3.
  - XW default.
  - A speed function (base + score[9:4], optional cap).
- No sub-module needed. The LFSR stays external and is shared.

Test Plan:
- Reset, then release -> obj_active=3'b001, slot0 X=630, score=0, speed=4, busy=0.
- run=1, rand_val=0, one frame_tick -> busy for 5 cycles, done pulse in cycle 5, slot0 X=626. A second tick during busy -> overrun=1 and X stays 626.
- rand_val=10'h300, 61 spaced ticks -> at tick 61 slot0 X=386 (<390) and slot1 spawns at X=640, type=3, obj_active=3'b011. At tick 60 (X=390) there is no spawn.
- Force slot0 to X=-38 at speed 4, then tick -> slot0 inactive, score=1. Advance score 15->16 -> speed becomes 5 after that DONE, not within it.
- All three slots active and the spawn condition true -> no spawn, newest unchanged. The spawn happens on the first tick after slot n retires.
- Assert clear during MOVE idx=1 -> next cycle in IDLE, reset-state outputs, overrun=0. With OBST_SPEED_CAP_EN and score=1023 -> speed=16; without it, speed=67.
